// File: rtl/mpy_accum_if.sv
// mpy_accum_if: handshake bundle between the MPY product stream, the job
// controller and the result consumer of mpy_accum.
//   master : drives start/len, p/p_valid, acc_ready; observes the rest
//   slave  : the accumulator (drives p_ready, acc, acc_valid, ovf, busy)
interface mpy_accum_if #(
    parameter int unsigned CNT_W = 8
);
    logic                start;
    logic [CNT_W-1:0]    len;
    logic signed [63:0]  p;
    logic                p_valid;
    logic                p_ready;
    logic signed [63:0]  acc;
    logic                acc_valid;
    logic                acc_ready;
    logic                ovf;
    logic                busy;

    modport master (
        output start, len, p, p_valid, acc_ready,
        input  p_ready, acc, acc_valid, ovf, busy
    );

    modport slave (
        input  start, len, p, p_valid, acc_ready,
        output p_ready, acc, acc_valid, ovf, busy
    );
endinterface

// File: rtl/mpy_accum.sv
// mpy_accum: sums a programmed number of 64-bit signed products into a
// 64-bit signed accumulator and presents the result with a sticky
// overflow flag over a valid/ready handshake.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mpy_accum_if.slave (start/len job request, p/p_valid/p_ready
//          product stream, acc/ovf/acc_valid/acc_ready result, busy)
// Config macro: MPY_ACCUM_SAT_EN - saturate on overflow instead of wrapping.
module mpy_accum #(
    parameter int unsigned CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    mpy_accum_if.slave  bus
);
    localparam int unsigned ACC_W = 64;
    localparam logic [ACC_W-1:0] POS_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] NEG_MAX = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc_q, acc_nxt;
    logic               ovf_q, ovf_nxt;
    logic [CNT_W-1:0]   rem_q, rem_nxt;
    logic               p_ready_q, acc_valid_q, busy_q;

    logic [ACC_W-1:0]   sum;
    logic               add_ovf;
    logic               xfer;

    // Overflow: operands agree in sign but the wrapped sum does not.
    always_comb begin
        sum     = acc_q + bus.p;
        add_ovf = (acc_q[ACC_W-1] == bus.p[ACC_W-1]) &&
                  (sum[ACC_W-1] != acc_q[ACC_W-1]);
        xfer    = p_ready_q & bus.p_valid;
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc_q;
        ovf_nxt   = ovf_q;
        rem_nxt   = rem_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_nxt = '0;
                    ovf_nxt = 1'b0;
                    if (bus.len != '0) begin
                        rem_nxt   = bus.len;
                        state_nxt = ACCUM;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            ACCUM: begin
                if (xfer) begin
`ifdef MPY_ACCUM_SAT_EN
                    // Both operands non-negative -> positive overflow.
                    if (add_ovf) acc_nxt = acc_q[ACC_W-1] ? NEG_MAX : POS_MAX;
                    else         acc_nxt = sum;
`else
                    acc_nxt = sum;
`endif
                    ovf_nxt = ovf_q | add_ovf;
                    rem_nxt = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.acc_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Datapath and handshake flags; flags mirror the state they enter.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            rem_q       <= '0;
            p_ready_q   <= 1'b0;
            acc_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            acc_q       <= acc_nxt;
            ovf_q       <= ovf_nxt;
            rem_q       <= rem_nxt;
            p_ready_q   <= (state_nxt == ACCUM);
            acc_valid_q <= (state_nxt == DONE);
            busy_q      <= (state_nxt != IDLE);
        end
    end

    assign bus.acc       = acc_q;
    assign bus.ovf       = ovf_q;
    assign bus.p_ready   = p_ready_q;
    assign bus.acc_valid = acc_valid_q;
    assign bus.busy      = busy_q;
endmodule
